bool_sweep_checker: RTL and testbench
=====================================

# bool_sweep_checker

Parametrised, self-checking exhaustive sweep engine for an N-input single-output combinational function. On a start pulse it walks every input vector 0..2^N-1 onto an external circuit under test, waits a programmable settle time, and compares the sampled response with a loadable expected truth table. It reports a mismatch count, the first failing vector and a pass flag. It sits beside a gate-level function block as its on-chip checker and replaces the open-loop vector sweep used for the 4-input functions.

## Interface
- N, default 4: number of function inputs; legal range 1..8.
- TT, default 16'hFC00 (2^N bits): reset value of the expected truth table. Bit k is the expected output for input vector k. The default encodes f = x3 & (x2 | x1).
- SETTLE, default 1: extra hold cycles per vector before sampling; legal range 0..15.

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
- abort  in  1  terminates a running sweep
- mode  in  1  0 = full sweep; 1 = stop at first mismatch; sampled with start
- tt_load  in  1  load tt_in into the expected table; honoured only in IDLE
- tt_in  in  2^N  new expected truth table
- dut_out  in  1  response of the circuit under test to vec
- vec  out  N  vector driven to the circuit under test; vec[N-1] maps to the MSB input
- busy  out  1  high while a sweep is running
- done  out  1  one-cycle pulse when a sweep completes (not asserted on abort)
- pass  out  1  1 when the last completed sweep had err_cnt == 0
- err_cnt  out  N+1  mismatch count; max 2^N, so it never overflows
- first_fail  out  N  first vector that mismatched; valid when fail_seen = 1
- fail_seen  out  1  at least one mismatch in the current or last sweep

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: vec = 0, busy = 0.
  - start → SETTLE. On that transition: err_cnt, fail_seen and first_fail cleared; pass cleared; mode latched; settle counter loaded with SETTLE.
- SETTLE: hold vec; decrement the counter. When it is 0 (or immediately if SETTLE = 0) → CHECK.
- CHECK: compare dut_out with tt[vec].
  - On mismatch: err_cnt += 1. If fail_seen = 0, set first_fail = vec and fail_seen = 1.
  - Exit → DONE if either vec = 2^N-1, or (latched mode = 1 and a mismatch occurred).
  - Otherwise vec += 1, reload the counter and → SETTLE.
- DONE: one cycle. done = 1, busy = 0, pass = (err_cnt == 0), vec returns to 0, → IDLE.
- abort: in SETTLE/CHECK → IDLE next edge. No done pulse; pass stays 0; err_cnt, first_fail and fail_seen keep their partial values. vec returns to 0. In IDLE or DONE, abort is ignored.
- Simultaneous events:
  - start + abort in IDLE: abort wins; no sweep.
  - start while busy: ignored.
  - tt_load + start in IDLE: the table loads and the sweep uses the new table.
  - tt_load while busy or in DONE: ignored.
- Result outputs hold until the next accepted start or reset.
- Async reset, including mid-sweep: state = IDLE, tt = TT, and all outputs = 0 (vec, busy, done, pass, err_cnt, first_fail, fail_seen) immediately, without waiting for a clock edge.

## Timing
- Cycle numbering: cycle 0 is the cycle in which start is sampled.
- busy rises in cycle 1. Vector k is driven during cycles 1 + k(SETTLE+1) .. (k+1)(SETTLE+1).
- dut_out is sampled on the last cycle of each vector window. The circuit under test therefore gets SETTLE full cycles plus one cycle of combinational path.
- Full sweep: done pulses in cycle 1 + 2^N(SETTLE+1). With the defaults this is cycle 33.
- Stop-first: for a first mismatch at vector k, done pulses in cycle 1 + (k+1)(SETTLE+1).
- busy and done are never high together. done is never high for more than one cycle.
- After tt_load in IDLE, the new table is effective from the next cycle.

## Test plan
Defaults apply throughout (N=4, TT=16'hFC00, SETTLE=1).
- Correct model: dut_out = vec[3] & (vec[2] | vec[1]), start, mode=0 → done in cycle 33, pass=1, err_cnt=0, fail_seen=0. vec steps 0..15, each held 2 cycles.
- dut_out stuck 0, mode=0 → err_cnt=6, first_fail=4'hA, fail_seen=1, pass=0, done in cycle 33.
- dut_out stuck 1, mode=1 → stops after vector 0: err_cnt=1, first_fail=0, done in cycle 3. Repeat with mode=0 → err_cnt=10.
- tt_load with tt_in=16'h0000, then dut_out stuck 0 → pass=1. Check the tt_load + start same-cycle case and tt_load during busy (ignored).
- abort in cycle 10 → busy=0 in cycle 11, no done, vec=0, partial err_cnt held. A following start runs a full, correct sweep. Also check start+abort in IDLE → no sweep.
- rst_n pulsed low mid-sweep (between edges) → all outputs 0 immediately, table reverts to 16'hFC00; after release, a sweep with the correct model passes.

Source files
------------

// File: rtl/bool_sweep_checker.sv
// Exhaustive sweep checker: drives every N-bit vector onto an external function,
// samples its response after a settle window and compares against a truth table.
module bool_sweep_checker #(
    parameter int unsigned           N      = 4,
    parameter logic [(1<<N)-1:0]     TT     = 16'hFC00,
    parameter int unsigned           SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic                 tt_load,
    input  logic [(1<<N)-1:0]    tt_in,
    input  logic                 dut_out,
    output logic [N-1:0]         vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N:0]           err_cnt,
    output logic [N-1:0]         first_fail,
    output logic                 fail_seen
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]   SETTLE_C = SETTLE[3:0];
    localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
    // With no settle cycles each vector window is just the CHECK cycle.
    localparam logic [1:0]   S_FIRST  = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    logic [1:0]          state;
    logic [3:0]          cnt;
    logic                mode_q;
    logic [(1<<N)-1:0]   tt;
    logic                miss;

    assign miss = (dut_out != tt[vec]);
    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tt         <= TT;
            vec        <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tt_load)
                        tt <= tt_in;
                    if (start && !abort) begin
                        err_cnt    <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                        pass       <= 1'b0;
                        mode_q     <= mode;
                        cnt        <= SETTLE_C;
                        vec        <= '0;
                        state      <= S_FIRST;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        vec   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1)
                            state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        vec   <= '0;
                        state <= S_IDLE;
                    end else begin
                        if (miss) begin
                            err_cnt <= err_cnt + 1'b1;
                            if (!fail_seen) begin
                                first_fail <= vec;
                                fail_seen  <= 1'b1;
                            end
                        end
                        if (vec == VEC_LAST || (mode_q && miss)) begin
                            // pass reflects the count including this cycle's compare
                            pass  <= (err_cnt == '0) && !miss;
                            vec   <= '0;
                            state <= S_DONE;
                        end else begin
                            vec   <= vec + 1'b1;
                            cnt   <= SETTLE_C;
                            state <= S_FIRST;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bool_sweep_checker.sv
// Directed plus randomized bench for bool_sweep_checker with a sweep-level reference model.
module tb_bool_sweep_checker;
    localparam int NV = 16;
    localparam int S  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, mode = 1'b0, tt_load = 1'b0;
    logic [15:0] tt_in = '0;
    logic        dut_out;
    logic [3:0]  vec;
    logic        busy, done, pass, fail_seen;
    logic [4:0]  err_cnt;
    logic [3:0]  first_fail;

    logic [15:0] flip = '0;
    logic [15:0] ttm = 16'hFC00;
    int n_cmp = 0, n_err = 0;

    bool_sweep_checker #(.N(4), .TT(16'hFC00), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .tt_load(tt_load), .tt_in(tt_in), .dut_out(dut_out), .vec(vec),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail(first_fail), .fail_seen(fail_seen)
    );

    always #5 clk = ~clk;

    function automatic logic fref(input logic [3:0] v);
        return v[3] & (v[2] | v[1]);
    endfunction

    assign dut_out = fref(vec) ^ flip[vec];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_tt(input logic [15:0] v);
        @(negedge clk);
        tt_load = 1'b1; tt_in = v;
        @(posedge clk); #1;
        tt_load = 1'b0;
        ttm = v;
    endtask

    // One sweep: ac = abort cycle (0 = none), lb = try a load while busy, ls = load with start.
    task automatic run(input string tag, input bit m, input int ac, input bit lb,
                       input bit ls, input logic [15:0] ld);
        int errs, ff, dc, kk;
        bit fs;
        @(negedge clk);
        start = 1'b1; mode = m;
        if (ls) begin tt_load = 1'b1; tt_in = ld; ttm = ld; end
        errs = 0; ff = 0; fs = 0; dc = 1 + NV*(S+1);
        for (int k = 0; k < NV; k++) begin
            if ((fref(k[3:0]) ^ flip[k]) != ttm[k]) begin
                errs++;
                if (!fs) begin ff = k; fs = 1; end
                if (m) begin dc = 1 + (k+1)*(S+1); break; end
            end
        end
        if (ac != 0) begin
            // only vectors whose CHECK cycle precedes the abort cycle are counted
            errs = 0; ff = 0; fs = 0;
            for (int k = 0; 2*(k+1) < ac; k++)
                if ((fref(k[3:0]) ^ flip[k]) != ttm[k]) begin
                    errs++;
                    if (!fs) begin ff = k; fs = 1; end
                end
        end
        @(posedge clk); #1;
        start = 1'b0; tt_load = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            abort   = (ac != 0) && (c == ac);
            tt_load = lb && (c == 3);
            tt_in   = ~ttm;
            @(negedge clk);
            if (ac != 0 && c == ac + 1) begin
                chk({tag, " abort state"}, {busy, done, vec, pass}, {1'b0, 1'b0, 4'h0, 1'b0});
                chk({tag, " abort results"}, {err_cnt, first_fail, fail_seen},
                    {5'(errs), 4'(ff), fs});
                break;
            end else if (ac == 0 && c == dc) begin
                chk({tag, " done cycle"}, {busy, done, vec}, {1'b0, 1'b1, 4'h0});
                chk({tag, " results"}, {pass, err_cnt, first_fail, fail_seen},
                    {errs == 0, 5'(errs), 4'(ff), fs});
                break;
            end else begin
                kk = (c - 1) / (S + 1);
                chk({tag, " sweep"}, {busy, done, vec}, {1'b1, 1'b0, 4'(kk)});
            end
            if (c == 40) chk({tag, " timeout"}, 32'd1, 32'd0);
            @(posedge clk); #1;
        end
        abort = 1'b0; tt_load = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " idle hold"}, {busy, done, pass, err_cnt, first_fail, fail_seen},
            {1'b0, 1'b0, (ac == 0) && errs == 0, 5'(errs), 4'(ff), fs});
    endtask

    initial begin
        #12;
        chk("reset outputs", {vec, busy, done, pass, err_cnt, first_fail, fail_seen}, 32'd0);
        rst_n = 1'b1;

        flip = 16'h0000;        run("correct", 1'b0, 0, 1'b0, 1'b0, 16'h0);
        flip = 16'hFC00;        run("stuck0", 1'b0, 0, 1'b0, 1'b0, 16'h0);
        flip = 16'h03FF;        run("stuck1 stop", 1'b1, 0, 1'b0, 1'b0, 16'h0);
        run("stuck1 full", 1'b0, 0, 1'b0, 1'b0, 16'h0);

        load_tt(16'h0000);
        flip = 16'hFC00;        run("load0 stuck0", 1'b0, 0, 1'b0, 1'b0, 16'h0);
        run("load busy", 1'b0, 0, 1'b1, 1'b0, 16'h0);
        flip = 16'h03FF;        run("load+start", 1'b0, 0, 1'b0, 1'b1, 16'hFFFF);

        // start with abort in IDLE must not begin a sweep
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk); chk("start+abort idle", {busy, done, vec}, 6'd0);
        @(negedge clk); chk("start+abort idle2", {busy, done}, 2'd0);

        load_tt(16'hFC00);
        flip = 16'h000F;        run("abort c10", 1'b0, 10, 1'b0, 1'b0, 16'h0);
        flip = 16'h0000;        run("after abort", 1'b0, 0, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(1, 0) == 1) load_tt(16'($urandom));
            flip = 16'($urandom & $urandom & $urandom);
            run("random", 1'($urandom_range(1, 0)), 0, 1'b0, 1'b0, 16'h0);
        end

        // async reset mid-sweep, with a non-default table loaded beforehand
        load_tt(16'h0000);
        flip = 16'hFFFF;
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async reset", {vec, busy, done, pass, err_cnt, first_fail, fail_seen}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ttm = 16'hFC00;
        flip = 16'h0000;        run("post reset", 1'b0, 0, 1'b0, 1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
